// File: rtl/spi_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_burst_ctrl_if
//
// Bundles every non-clock, non-reset signal of spi_burst_ctrl: the burst
// command, the TX valid/ready stream, the RX strobe, the status flags and the
// link to the single-byte SPI master.
//
// Modports:
//   master : the side that issues commands, sources TX bytes and hosts the SPI
//            master (register/DMA logic plus the master, or a testbench)
//   slave  : spi_burst_ctrl itself
//
// Parameter:
//   CNT_W  : width of byte_count; must equal $clog2(MAX_BYTES+1) of the
//            attached controller.
// -----------------------------------------------------------------------------
interface spi_burst_ctrl_if #(
    parameter int CNT_W = 5
);
    // Burst command
    logic             start;
    logic [CNT_W-1:0] byte_count;
    logic             abort;

    // TX byte stream into the controller
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    // RX byte strobe out of the controller
    logic [7:0]       rx_data;
    logic             rx_valid;

    // Status
    logic             busy;
    logic             done;
    logic             error;

    // Link to the single-byte SPI master
    logic             m_spi_en;
    logic [7:0]       m_spi_mosi_data;
    logic [7:0]       m_spi_miso_data;
    logic             m_payload_done;

    modport master (
        output start, byte_count, abort,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        input  busy, done, error,
        input  m_spi_en, m_spi_mosi_data,
        output m_spi_miso_data, m_payload_done
    );

    modport slave (
        input  start, byte_count, abort,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        output busy, done, error,
        output m_spi_en, m_spi_mosi_data,
        input  m_spi_miso_data, m_payload_done
    );
endinterface

// File: rtl/spi_burst_ctrl.sv
// -----------------------------------------------------------------------------
// spi_burst_ctrl
//
// Runs multi-byte bursts on a single-byte SPI master. A burst command carries
// a byte count (clamped to MAX_BYTES). For each byte the controller pulls one
// TX byte over a valid/ready stream, raises m_spi_en until the master reports
// m_payload_done, returns the received byte on a one-cycle rx_valid strobe and
// then holds m_spi_en low for GAP_CYCLES cycles before the next byte. A
// watchdog and the abort input guarantee every burst ends with a done pulse;
// error records whether the last burst ended by timeout or abort.
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : spi_burst_ctrl_if.slave (command, TX/RX streams, status, master link)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module spi_burst_ctrl #(
    parameter int MAX_BYTES      = 16,
    parameter int GAP_CYCLES     = 4,     // >= 1
    parameter int TIMEOUT_CYCLES = 4096   // >= 2
) (
    input logic            clk,
    input logic            rst,
    spi_burst_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BYTES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_XFER,
        S_GAP,
        S_FINISH
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  remaining_reg;
    logic [WD_W-1:0]   wdog_reg;
    logic [GAP_W-1:0]  gap_reg;

    logic              tx_ready_reg;
    logic [7:0]        rx_data_reg;
    logic              rx_valid_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;
    logic              m_spi_en_reg;
    logic [7:0]        m_spi_mosi_reg;

    logic              tx_fire;
    logic              xfer_end;
    logic              wdog_expired;
    logic              gap_expired;
    logic              last_byte;
    logic              abortable;
    logic [CNT_W-1:0]  count_clamped;

    // tx_ready is high throughout LOAD, so the handshake is tx_valid in LOAD.
    // Abort wins over a same-cycle handshake: the byte is not sent.
    assign tx_fire      = (state_reg == S_LOAD) && bus.tx_valid && tx_ready_reg && !bus.abort;
    // A completed byte is delivered even when abort arrives in the same cycle.
    assign xfer_end     = (state_reg == S_XFER) && bus.m_payload_done;
    assign wdog_expired = (wdog_reg == WD_W'(TIMEOUT_CYCLES - 1));
    assign gap_expired  = (gap_reg == GAP_W'(GAP_CYCLES - 1));
    assign last_byte    = (remaining_reg <= CNT_W'(1));
    assign abortable    = (state_reg == S_LOAD) || (state_reg == S_XFER) || (state_reg == S_GAP);
    assign count_clamped = (bus.byte_count > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : bus.byte_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = (bus.byte_count == '0) ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    state_next = S_FINISH;
                end else if (tx_fire) begin
                    state_next = S_XFER;
                end
            end
            S_XFER: begin
                if (bus.m_payload_done) begin
                    state_next = (bus.abort || last_byte) ? S_FINISH : S_GAP;
                end else if (bus.abort || wdog_expired) begin
                    state_next = S_FINISH;
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    state_next = S_FINISH;
                end else if (gap_expired) begin
                    state_next = S_LOAD;
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // they describe: done and the last rx_valid both appear in FINISH.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_reg  <= '0;
            wdog_reg       <= '0;
            gap_reg        <= '0;
            tx_ready_reg   <= 1'b0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            m_spi_en_reg   <= 1'b0;
            m_spi_mosi_reg <= '0;
        end else begin
            tx_ready_reg <= (state_next == S_LOAD);
            busy_reg     <= (state_next != S_IDLE);
            done_reg     <= (state_next == S_FINISH);
            m_spi_en_reg <= (state_next == S_XFER);
            rx_valid_reg <= xfer_end;

            if (xfer_end) begin
                rx_data_reg <= bus.m_spi_miso_data;
            end
            if (tx_fire) begin
                m_spi_mosi_reg <= bus.tx_data;
            end

            if ((state_reg == S_IDLE) && bus.start) begin
                remaining_reg <= count_clamped;
            end else if (xfer_end && (remaining_reg != '0)) begin
                remaining_reg <= remaining_reg - 1'b1;
            end

            // Both counters sit at zero outside their state, so entering XFER
            // or GAP always starts a fresh count.
            if (state_reg == S_XFER) begin
                wdog_reg <= wdog_reg + 1'b1;
            end else begin
                wdog_reg <= '0;
            end
            if (state_reg == S_GAP) begin
                gap_reg <= gap_reg + 1'b1;
            end else begin
                gap_reg <= '0;
            end

            if ((state_reg == S_IDLE) && bus.start) begin
                error_reg <= 1'b0;
            end else if ((abortable && bus.abort) ||
                         ((state_reg == S_XFER) && !bus.m_payload_done && wdog_expired)) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign bus.tx_ready        = tx_ready_reg;
    assign bus.rx_data         = rx_data_reg;
    assign bus.rx_valid        = rx_valid_reg;
    assign bus.busy            = busy_reg;
    assign bus.done            = done_reg;
    assign bus.error           = error_reg;
    assign bus.m_spi_en        = m_spi_en_reg;
    assign bus.m_spi_mosi_data = m_spi_mosi_reg;
endmodule
